// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and the address-width helper
// used by the synchronous FIFO and its async successors.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2, floored at 1 so a pointer always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// DEPTH x DATA_SIZE storage: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 250,
    parameter int ADDR_W    = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Store the write word on the rising edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axil_sdram_sync_fifo.sv
// Single-clock FIFO for the AXI4-Lite-to-SDRAM wrapper. Arbitrary depth,
// standard or first-word-fall-through read, programmable almost flags,
// exact fill count and sticky overflow/underflow flags.
module axil_sdram_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 250,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = 240,
    parameter int AE_THRESH = 8,
    localparam int ADDR_W   = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_W:0]      fill_count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);

    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0]  CNT_AE   = CNT_W'(AE_THRESH);

    if (DEPTH < 2) begin : g_chk_depth
        $error("axil_sdram_sync_fifo: DEPTH must be at least 2");
    end
    if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_chk_thresh
        $error("axil_sdram_sync_fifo: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_chk_mode
        $error("axil_sdram_sync_fifo: FWFT must be 0 or 1");
    end

    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 wr_acc;
    logic                 rd_acc;

    // Explicit wrap at DEPTH-1 so any depth works, not just powers of two.
    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + ADDR_W'(1);
    endfunction

    // Full blocks the write and empty blocks the read, so a collision at
    // either boundary degenerates to the one operation that is legal.
    assign wr_acc = wr_en && !fifo_full;
    assign rd_acc = rd_en && !fifo_empty;

    assign fifo_full    = (fill_count == CNT_FULL);
    assign fifo_empty   = (fill_count == '0);
    assign almost_full  = (fill_count >= CNT_AF);
    assign almost_empty = (fill_count <= CNT_AE);

    fifo_dpram #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Pointer and occupancy bookkeeping for accepted operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   fill_count <= fill_count + CNT_W'(1);
                2'b01:   fill_count <= fill_count - CNT_W'(1);
                default: fill_count <= fill_count;
            endcase
        end
    end

    // Sticky error flags; a fresh error beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && fifo_empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented straight from the RAM; rd_en acts as a pop.
        assign data_out   = rd_data;
        assign data_valid = !fifo_empty;
    end else begin : g_std
        logic [DATA_SIZE-1:0] dout_q;
        logic                 dv_q;

        // Registered read: data lands one cycle after rd_en with a valid pulse.
        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else begin
                dv_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= rd_data;
                end
            end
        end

        assign data_out   = dout_q;
        assign data_valid = dv_q;
    end

endmodule

// File: tb/tb_axil_sdram_sync_fifo.sv
// Directed bench for axil_sdram_sync_fifo: a vector table for the standard
// mode instance plus short hand-written sequences for reset and FWFT.
module tb_axil_sdram_sync_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset;

    logic          wr_en, rd_en, err_clr;
    logic [DW-1:0] data_in, data_out;
    logic          data_valid, fifo_full, fifo_empty, almost_full, almost_empty;
    logic          overflow, underflow;
    logic [CW-1:0] fill_count;

    logic          f_wr_en, f_rd_en, f_err_clr;
    logic [DW-1:0] f_data_in, f_data_out;
    logic          f_data_valid, f_fifo_full, f_fifo_empty, f_almost_full, f_almost_empty;
    logic          f_overflow, f_underflow;
    logic [CW-1:0] f_fill_count;

    always #5 clk = ~clk;

    axil_sdram_sync_fifo #(
        .DATA_SIZE (DW), .DEPTH (DEPTH), .FWFT (0), .AF_THRESH (AF), .AE_THRESH (AE)
    ) dut_std (
        .clk (clk), .reset (reset), .wr_en (wr_en), .data_in (data_in), .rd_en (rd_en),
        .data_out (data_out), .data_valid (data_valid), .fifo_full (fifo_full),
        .fifo_empty (fifo_empty), .almost_full (almost_full), .almost_empty (almost_empty),
        .fill_count (fill_count), .overflow (overflow), .underflow (underflow),
        .err_clr (err_clr)
    );

    axil_sdram_sync_fifo #(
        .DATA_SIZE (DW), .DEPTH (DEPTH), .FWFT (1), .AF_THRESH (AF), .AE_THRESH (AE)
    ) dut_fwft (
        .clk (clk), .reset (reset), .wr_en (f_wr_en), .data_in (f_data_in), .rd_en (f_rd_en),
        .data_out (f_data_out), .data_valid (f_data_valid), .fifo_full (f_fifo_full),
        .fifo_empty (f_fifo_empty), .almost_full (f_almost_full),
        .almost_empty (f_almost_empty), .fill_count (f_fill_count),
        .overflow (f_overflow), .underflow (f_underflow), .err_clr (f_err_clr)
    );

    typedef struct {
        logic          wr;
        logic          rd;
        logic          clr;
        logic [DW-1:0] din;
        int            cnt;
        logic [DW-1:0] dout;
        logic          dv;
        logic          ovf;
        logic          udf;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void add(input logic wr, input logic rd, input logic clr,
                                input logic [DW-1:0] din, input int cnt,
                                input logic [DW-1:0] dout, input logic dv,
                                input logic ovf, input logic udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt;
        v.dout = dout; v.dv = dv; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_std(input string tag, input int cnt, input logic [DW-1:0] dout,
                             input logic dv, input logic ovf, input logic udf);
        logic [3:0] exp_flags;
        exp_flags = {cnt == DEPTH, cnt == 0, cnt >= AF, cnt <= AE};
        chk({tag, " count"}, DW'(fill_count), DW'(cnt));
        chk({tag, " flags"}, DW'({fifo_full, fifo_empty, almost_full, almost_empty}),
            DW'(exp_flags));
        chk({tag, " data_out"}, data_out, dout);
        chk({tag, " data_valid"}, DW'(data_valid), DW'(dv));
        chk({tag, " overflow"}, DW'(overflow), DW'(ovf));
        chk({tag, " underflow"}, DW'(underflow), DW'(udf));
    endtask

    initial begin
        //   wr rd clr din          cnt dout         dv ovf udf
        add(1, 0, 0, 32'h00,       1, 32'h00,       0, 0, 0);
        add(1, 0, 0, 32'h11,       2, 32'h00,       0, 0, 0);
        add(1, 0, 0, 32'h22,       3, 32'h00,       0, 0, 0);
        add(1, 0, 0, 32'h33,       4, 32'h00,       0, 0, 0);
        add(1, 0, 0, 32'h44,       5, 32'h00,       0, 0, 0);
        add(0, 1, 0, 32'h0,        4, 32'h00,       1, 0, 0);
        add(0, 1, 0, 32'h0,        3, 32'h11,       1, 0, 0);
        add(1, 0, 0, 32'h55,       4, 32'h11,       0, 0, 0);
        add(1, 0, 0, 32'h66,       5, 32'h11,       0, 0, 0);
        add(1, 1, 0, 32'h77,       4, 32'h22,       1, 1, 0);
        add(0, 1, 0, 32'h0,        3, 32'h33,       1, 1, 0);
        add(0, 1, 0, 32'h0,        2, 32'h44,       1, 1, 0);
        add(0, 1, 0, 32'h0,        1, 32'h55,       1, 1, 0);
        add(0, 1, 0, 32'h0,        0, 32'h66,       1, 1, 0);
        add(0, 0, 1, 32'h0,        0, 32'h66,       0, 0, 0);
        add(1, 1, 0, 32'h88,       1, 32'h66,       0, 0, 1);
        add(0, 1, 0, 32'h0,        0, 32'h88,       1, 0, 1);
        add(0, 1, 0, 32'h0,        0, 32'h88,       0, 0, 1);
        add(0, 0, 1, 32'h0,        0, 32'h88,       0, 0, 0);
        add(1, 0, 0, 32'h100,      1, 32'h88,       0, 0, 0);
        add(1, 0, 0, 32'h101,      2, 32'h88,       0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            add(1, 1, 0, 32'h102 + DW'(k), 2, 32'h100 + DW'(k), 1, 0, 0);
        end
        add(1, 0, 0, 32'h200,      3, 32'h109,      0, 0, 0);
        add(1, 0, 0, 32'h201,      4, 32'h109,      0, 0, 0);
        add(1, 0, 0, 32'h202,      5, 32'h109,      0, 0, 0);
        add(1, 0, 0, 32'h203,      5, 32'h109,      0, 1, 0);
        add(1, 0, 1, 32'h204,      5, 32'h109,      0, 1, 0);
        add(0, 0, 1, 32'h0,        5, 32'h109,      0, 0, 0);
        add(0, 1, 0, 32'h0,        4, 32'h10A,      1, 0, 0);
        add(0, 1, 0, 32'h0,        3, 32'h10B,      1, 0, 0);
        add(0, 1, 0, 32'h0,        2, 32'h200,      1, 0, 0);
        add(0, 1, 0, 32'h0,        1, 32'h201,      1, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h202,      1, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h202,      0, 0, 1);
        add(0, 0, 1, 32'h0,        0, 32'h202,      0, 0, 0);

        // Reset held two cycles with a write pending: nothing may be stored.
        reset     = 1'b1;
        wr_en     = 1'b1;
        rd_en     = 1'b0;
        err_clr   = 1'b0;
        data_in   = 32'hDEAD_BEEF;
        f_wr_en   = 1'b0;
        f_rd_en   = 1'b0;
        f_err_clr = 1'b0;
        f_data_in = '0;
        repeat (2) @(negedge clk);
        check_std("reset", 0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("fwft reset count", DW'(f_fill_count), 32'd0);
        chk("fwft reset valid", DW'(f_data_valid), 32'd0);
        wr_en = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            wr_en   = vecs[i].wr;
            rd_en   = vecs[i].rd;
            err_clr = vecs[i].clr;
            data_in = vecs[i].din;
            @(negedge clk);
            check_std($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].dv,
                      vecs[i].ovf, vecs[i].udf);
        end
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;

        // FWFT: head visible the cycle after the first write, pop empties it.
        f_wr_en   = 1'b1;
        f_data_in = 32'hA5;
        @(negedge clk);
        f_wr_en = 1'b0;
        chk("fwft head", f_data_out, 32'hA5);
        chk("fwft valid", DW'(f_data_valid), 32'd1);
        chk("fwft not empty", DW'(f_fifo_empty), 32'd0);
        f_rd_en = 1'b1;
        @(negedge clk);
        f_rd_en = 1'b0;
        chk("fwft pop empty", DW'(f_fifo_empty), 32'd1);
        chk("fwft pop valid", DW'(f_data_valid), 32'd0);
        f_wr_en   = 1'b1;
        f_data_in = 32'hB1;
        @(negedge clk);
        f_data_in = 32'hB2;
        @(negedge clk);
        f_wr_en = 1'b0;
        chk("fwft head2", f_data_out, 32'hB1);
        chk("fwft count2", DW'(f_fill_count), 32'd2);
        f_rd_en = 1'b1;
        @(negedge clk);
        chk("fwft next word", f_data_out, 32'hB2);
        chk("fwft count1", DW'(f_fill_count), 32'd1);
        @(negedge clk);
        f_rd_en = 1'b0;
        chk("fwft drained", DW'(f_fifo_empty), 32'd1);
        chk("fwft underflow", DW'(f_underflow), 32'd0);

        // Reset mid-operation discards stored words.
        wr_en   = 1'b1;
        data_in = 32'h301;
        @(negedge clk);
        data_in = 32'h302;
        @(negedge clk);
        wr_en = 1'b0;
        chk("pre-reset count", DW'(fill_count), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_std("mid reset", 0, 32'h0, 1'b0, 1'b0, 1'b0);
        wr_en   = 1'b1;
        data_in = 32'h303;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_std("post reset read", 0, 32'h303, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
